// File: rtl/uart_mem_loader.sv
// uart_mem_loader: parses framed byte streams from a UART receiver and
// writes the payload into an on-chip memory through 32-bit word writes.
// Frame: SYNC, A2 A1 A0 (byte address), L1 L0 (length), payload, CK (XOR).
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on the current state (and
// reset), never on in_valid, so the sender may hold data until accepted.
module uart_mem_loader #(
    parameter int         DEPTH_WORDS = 100240,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [16:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic        mem_clken,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ADDR2   = 4'd1,
        ADDR1   = 4'd2,
        ADDR0   = 4'd3,
        LEN1    = 4'd4,
        LEN0    = 4'd5,
        CHECK   = 4'd6,
        DATA    = 4'd7,
        FLUSH   = 4'd8,
        DISCARD = 4'd9,
        CSUM    = 4'd10,
        REPORT  = 4'd11
    } state_t;

    // First byte address past the memory; the last payload byte must be below it.
    localparam logic [24:0] LIMIT_BYTES = 25'(DEPTH_WORDS * 4);

    state_t      state_q, state_d;
    logic [23:0] addr_q;       // frame start byte address
    logic [15:0] len_q;        // frame payload length
    logic [15:0] cnt_q;        // payload bytes still to accept
    logic [18:0] cur_addr_q;   // byte address of next payload byte (in-range frames only)
    logic [7:0]  csum_q;       // running XOR from A2 onwards
    logic [31:0] word_q;       // lane register being assembled
    logic [3:0]  be_q;         // lanes filled in word_q
    logic [16:0] word_addr_q;  // word address of word_q
    logic [1:0]  frame_err_q;  // status of the frame in flight
    logic [1:0]  err_q;        // status reported with the last done

    logic        accept;
    logic [24:0] end_addr;
    logic        out_of_range;
    logic [1:0]  lane;
    logic        last_byte;
    logic [1:0]  final_err;

    assign accept       = in_valid && in_ready;
    assign end_addr     = {1'b0, addr_q} + {9'd0, len_q} - 25'd1;
    assign out_of_range = (end_addr >= LIMIT_BYTES);
    assign lane         = cur_addr_q[1:0];
    assign last_byte    = (cnt_q == 16'd1);
    assign final_err    = ((frame_err_q == 2'd0) && (in_data != csum_q)) ? 2'd2 : frame_err_q;

    // Outputs decoded from state; reset forces every strobe and ready low.
    assign in_ready       = !reset && (state_q inside {IDLE, ADDR2, ADDR1, ADDR0, LEN1, LEN0,
                                                       DATA, DISCARD, CSUM});
    assign mem_write      = !reset && (state_q == FLUSH);
    assign mem_chipselect = mem_write;
    assign mem_address    = word_addr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = word_q;
    assign mem_clken      = 1'b1;
    assign busy           = !reset && (state_q != IDLE) && (state_q != REPORT);
    assign done           = !reset && (state_q == REPORT);
    assign err            = err_q;
    assign dbg_state      = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic for the frame parser.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && in_data == SYNC_BYTE) state_d = ADDR2;
            ADDR2:   if (accept) state_d = ADDR1;
            ADDR1:   if (accept) state_d = ADDR0;
            ADDR0:   if (accept) state_d = LEN1;
            LEN1:    if (accept) state_d = LEN0;
            LEN0:    if (accept) state_d = CHECK;
            CHECK: begin
                if (len_q == 16'd0)    state_d = CSUM;
                else if (out_of_range) state_d = DISCARD;
                else                   state_d = DATA;
            end
            DATA:    if (accept && (lane == 2'd3 || last_byte)) state_d = FLUSH;
            FLUSH:   state_d = (cnt_q != 16'd0) ? DATA : CSUM;
            DISCARD: if (accept && last_byte) state_d = CSUM;
            CSUM:    if (accept) state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: header capture, checksum, lane packing and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            cur_addr_q  <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            be_q        <= '0;
            word_addr_q <= '0;
            frame_err_q <= '0;
            err_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept && in_data == SYNC_BYTE) begin
                    csum_q      <= '0;
                    frame_err_q <= '0;
                end
                ADDR2: if (accept) begin
                    addr_q[23:16] <= in_data;
                    csum_q        <= csum_q ^ in_data;
                end
                ADDR1: if (accept) begin
                    addr_q[15:8] <= in_data;
                    csum_q       <= csum_q ^ in_data;
                end
                ADDR0: if (accept) begin
                    addr_q[7:0] <= in_data;
                    csum_q      <= csum_q ^ in_data;
                end
                LEN1: if (accept) begin
                    len_q[15:8] <= in_data;
                    csum_q      <= csum_q ^ in_data;
                end
                LEN0: if (accept) begin
                    len_q[7:0] <= in_data;
                    csum_q     <= csum_q ^ in_data;
                end
                CHECK: begin
                    cnt_q      <= len_q;
                    cur_addr_q <= addr_q[18:0];
                    word_q     <= '0;
                    be_q       <= '0;
                    if (len_q == 16'd0)    frame_err_q <= 2'd3;
                    else if (out_of_range) frame_err_q <= 2'd1;
                    else                   frame_err_q <= 2'd0;
                end
                DATA: if (accept) begin
                    word_q[8*lane +: 8] <= in_data;
                    be_q[lane]          <= 1'b1;
                    word_addr_q         <= cur_addr_q[18:2];
                    cur_addr_q          <= cur_addr_q + 19'd1;
                    cnt_q               <= cnt_q - 16'd1;
                    csum_q              <= csum_q ^ in_data;
                end
                FLUSH: begin
                    word_q <= '0;
                    be_q   <= '0;
                end
                DISCARD: if (accept) begin
                    cnt_q  <= cnt_q - 16'd1;
                    csum_q <= csum_q ^ in_data;
                end
                CSUM: if (accept) begin
                    frame_err_q <= final_err;
                    err_q       <= final_err;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Testbench for uart_mem_loader: frame vectors from a table, expected memory
// writes and statuses queued as frames are driven, checked as they appear.
module tb_uart_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [3:0]  dbg_state;

    uart_mem_loader dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .busy(busy),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int write_cnt = 0;
    int done_cnt = 0;
    logic [1:0] last_err = 2'd0;

    // Expected write: {word address, byteenable, data}
    logic [52:0] exp_q[$];
    logic [1:0]  err_exp_q[$];

    typedef struct {
        logic [23:0] addr;
        logic [15:0] len;
        logic [63:0] pay;      // byte i at pay[8*i +: 8]
        logic        ck_flip;
        logic [1:0]  exp_err;
        int          exp_writes;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    // Driver: present a byte and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("byte_accept_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Reference model: pack bytes by address into word writes.
    task automatic push_writes(input logic [23:0] addr, input logic [15:0] len,
                               input logic [63:0] pay);
        logic [31:0] w;
        logic [3:0]  be;
        logic [23:0] a;
        w  = '0;
        be = '0;
        for (int i = 0; i < int'(len); i++) begin
            a = addr + 24'(i);
            w[8*a[1:0] +: 8] = pay[8*i +: 8];
            be[a[1:0]] = 1'b1;
            if (a[1:0] == 2'd3 || i == int'(len) - 1) begin
                exp_q.push_back({a[18:2], be, w});
                w  = '0;
                be = '0;
            end
        end
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] ck;
        int w0;
        int d0;
        int n;
        w0 = write_cnt;
        d0 = done_cnt;
        if (v.exp_err == 2'd0 || v.exp_err == 2'd2) push_writes(v.addr, v.len, v.pay);
        err_exp_q.push_back(v.exp_err);
        ck = v.addr[23:16] ^ v.addr[15:8] ^ v.addr[7:0] ^ v.len[15:8] ^ v.len[7:0];
        for (int i = 0; i < int'(v.len); i++) ck = ck ^ v.pay[8*i +: 8];
        if (v.ck_flip) ck = ck ^ 8'h01;

        send_byte(8'hA5);
        check("busy_after_sync", 64'(busy), 64'd1);
        check("err_held", 64'(err), 64'(last_err));
        send_byte(v.addr[23:16]);
        send_byte(v.addr[15:8]);
        send_byte(v.addr[7:0]);
        send_byte(v.len[15:8]);
        send_byte(v.len[7:0]);
        for (int i = 0; i < int'(v.len); i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_byte(v.pay[8*i +: 8]);
        end
        send_byte(ck);

        n = 0;
        while (done_cnt == d0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        check("write_count", 64'(write_cnt - w0), 64'(v.exp_writes));
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        last_err = v.exp_err;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [52:0] e;
        logic [31:0] m;
        if (mem_write || mem_chipselect) begin
            check("cs_eq_write", 64'(mem_chipselect), 64'(mem_write));
            if (mem_write) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    m = {{8{e[35]}}, {8{e[34]}}, {8{e[33]}}, {8{e[32]}}};
                    check("wr_addr", 64'(mem_address), 64'(e[52:36]));
                    check("wr_be", 64'(mem_byteenable), 64'(e[35:32]));
                    check("wr_data", 64'(mem_writedata & m), 64'(e[31:0] & m));
                end
            end
        end
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", 64'(busy), 64'd0);
            if (err_exp_q.size() == 0) fail_now("unexpected_done");
            else check("err_at_done", 64'(err), 64'(err_exp_q.pop_front()));
        end
    end

    initial begin
        int w0;
        vecs[0] = '{24'h000010, 16'd4, 64'h0000_0000_4433_2211, 1'b0, 2'd0, 1};
        vecs[1] = '{24'h000006, 16'd3, 64'h0000_0000_00CC_BBAA, 1'b0, 2'd0, 2};
        vecs[2] = '{24'h061E3C, 16'd8, 64'h0807_0605_0403_0201, 1'b0, 2'd1, 0};
        vecs[3] = '{24'h000010, 16'd4, 64'h0000_0000_4433_2211, 1'b1, 2'd2, 1};
        vecs[4] = '{24'h000000, 16'd0, 64'h0,                   1'b0, 2'd3, 0};
        vecs[5] = '{24'h061E38, 16'd8, {$urandom, $urandom},     1'b0, 2'd0, 2};
        vecs[6] = '{24'h000003, 16'd6, {$urandom, $urandom},     1'b0, 2'd0, 3};

        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_write", 64'(mem_write), 64'd0);
        check("rst_cs", 64'(mem_chipselect), 64'd0);
        check("rst_be", 64'(mem_byteenable), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_wdata", 64'(mem_writedata), 64'd0);
        check("clken", 64'(mem_clken), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i]);
            if (i == 4) begin
                w0 = done_cnt;
                send_byte(8'h3C);
                @(negedge clk);
                check("garbage_dropped_busy", 64'(busy), 64'd0);
                check("garbage_no_done", 64'(done_cnt - w0), 64'd0);
            end
        end

        // Reset in the middle of a word: two of four payload bytes in.
        w0 = write_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_write", 64'(mem_write), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        repeat (5) @(negedge clk);
        check("midrst_no_write", 64'(write_cnt - w0), 64'd0);
        last_err = 2'd0;
        send_frame(vecs[0]);

        repeat (3) @(negedge clk);
        check("err_q_drained", 64'(err_exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 DEPTH_WORDS, 100240, depth of downstream on-chip memory in 32-bit words.
REQ-002 SYNC_BYTE, 8'hA5, frame start marker.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  received byte from UART RX stream.
REQ-006 in_valid  input  1  in_data valid; byte accepted when in_valid & in_ready.
REQ-007 in_ready  output  1  loader can accept a byte this cycle.
REQ-008 mem_address  output  17  word address to memory slave.
REQ-009 mem_byteenable  output  4  lane enables; bit n = writedata[8n+7:8n].
REQ-010 mem_chipselect  output  1  memory select, asserted only with mem_write.
REQ-011 mem_write  output  1  one-cycle write strobe.
REQ-012 mem_writedata  output  32  packed write word.
REQ-013 mem_clken  output  1  memory clock enable; constant 1.
REQ-014 busy  output  1  high from accepted SYNC_BYTE until done pulse.
REQ-015 done  output  1  one-cycle pulse at frame end.
REQ-016 err  output  2  frame status, valid with done and held until next done: 0 ok, 1 range, 2 checksum, 3 zero length.

Function
REQ-017 Frame format, in order: SYNC_BYTE, A2, A1, A0 (24-bit byte address, MSB first), L1, L0 (16-bit payload length, MSB first), payload bytes, CK.
REQ-018 CK SHALL equal the XOR of all frame bytes from A2 through the last payload byte.
REQ-019 States: IDLE, ADDR2, ADDR1, ADDR0, LEN1, LEN0, CHECK, DATA, FLUSH, DISCARD, CSUM, REPORT.
REQ-020 IDLE: accept and drop every byte; a SYNC_BYTE moves to ADDR2 and clears the checksum accumulator.
REQ-021 ADDR2..LEN0: one accepted byte per state, in frame order.
REQ-022 CHECK (one cycle, in_ready=0):
- len==0 -> err=3, go to CSUM;
- (addr+len-1)>>2 >= DEPTH_WORDS -> err=1, go to DISCARD;
- otherwise -> DATA.
REQ-023 DATA byte placement: byte at byte address a goes to lane a[1:0] of word a>>2; its byteenable bit is set.
REQ-024 DATA flush: after accepting a byte into lane 3, or the last payload byte, go to FLUSH.
REQ-025 FLUSH (exactly one cycle, in_ready=0):
- mem_write=mem_chipselect=1 with the packed word, enables and address;
- lane register and enables then clear;
- go to DATA if bytes remain, else CSUM.
REQ-026 Write latency: strobe occurs the cycle after the completing byte is accepted; at most one write per word.
REQ-027 Unaligned start/end: only lanes actually received SHALL be enabled; other lanes are don't-care data.
REQ-028 DISCARD: accept and drop len payload bytes with no memory strobe, then CSUM.
REQ-029 CSUM: accept CK.
- mismatch and err still 0 -> err=2;
- go to REPORT.
REQ-030 Checksum error SHALL NOT undo writes already issued.
REQ-031 REPORT: done=1 for one cycle, busy=0, then IDLE.
REQ-032 in_ready=1 in IDLE, ADDR*, LEN*, DATA, DISCARD, CSUM; 0 in CHECK, FLUSH, REPORT.
REQ-033 Arithmetic:
- address+length computed at 25 bits, no wrap;
- the length counter decrements per accepted payload byte.
REQ-034 mem_write and mem_chipselect SHALL be 0 outside FLUSH.

Reset
REQ-035 On reset:
- state=IDLE; busy=0, done=0, err=0, in_ready=0;
- mem_write=0, mem_chipselect=0, mem_byteenable=0, mem_address=0, mem_writedata=0;
- counters and checksum cleared.
REQ-036 Reset mid-frame: the partial word is discarded; no write is issued in or after the reset cycle; in_ready=1 from the first cycle after reset deasserts.

Verification
REQ-037 Aligned frame: A5 00 00 10, len 00 04, payload 11 22 33 44, correct CK -> one write: addr 4, be 4'hF, data 32'h44332211; done with err=0.
REQ-038 Unaligned frame: addr 0x000006, len 3, payload AA BB CC ->
- write 1: addr 1, be 4'hC, data[31:16]=16'hBBAA;
- write 2: addr 2, be 4'h1, data[7:0]=8'hCC;
- err=0.
REQ-039 Range error: addr 0x061E3C (word 100239), len 8 -> no write, 8 payload bytes consumed, err=1.
REQ-040 Bad checksum: aligned frame with CK^8'h01 -> write still occurs; err=2.
REQ-041 Zero length, then garbage: len 0 -> err=3, no write; a following byte 3C in IDLE is dropped; the next A5 starts a new frame.
REQ-042 Reset after byte 2 of a word's payload -> no write; then a valid frame completes with err=0.
